// File: rtl/atm_money_ctrl_p_pkg.sv
// rtl/atm_money_ctrl_p_pkg.sv - shared types and constants for the ATM money controller
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    CHECK  = 2'd2,
    RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_NOMONEY = 2'd1,
    RES_LIMIT   = 2'd2
  } result_t;

  localparam logic MODE_WD  = 1'b0;
  localparam logic MODE_DEP = 1'b1;

endpackage

// File: rtl/atm_money_ctrl_p_if.sv
// rtl/atm_money_ctrl_p_if.sv - request/result bundle between auth FSM, controller and display
interface atm_money_ctrl_p_if #(
  parameter int N_SEL = 2,
  parameter int BAL_W = 12
);
  logic                  auth;
  logic                  mode;
  logic [N_SEL-1:0]      sel;
  logic                  req;
  logic                  ok;
  logic                  nomoney;
  logic                  limit;
  logic                  busy;
  logic [2**N_SEL-1:0]   amount_onehot;
  logic [BAL_W-1:0]      balance;
  logic [1:0]            state_dbg;

  modport master (
    output auth, mode, sel, req,
    input  ok, nomoney, limit, busy, amount_onehot, balance, state_dbg
  );

  modport slave (
    input  auth, mode, sel, req,
    output ok, nomoney, limit, busy, amount_onehot, balance, state_dbg
  );
endinterface

// File: rtl/atm_money_ctrl_p_rise_detect.sv
// rtl/atm_money_ctrl_p_rise_detect.sv - registered rising-edge detector for level inputs
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/atm_money_ctrl_p.sv
// rtl/atm_money_ctrl_p.sv - balance register with withdraw/deposit FSM, session limit and result hold
module atm_money_ctrl_p
  import atm_pkg::*;
#(
  parameter int BAL_W    = 12,
  parameter int STEP     = 100,
  parameter int N_SEL    = 2,
  parameter int INIT_BAL = 1000,
  parameter int MAX_WD   = 3,
  parameter int HOLD_CYC = 4
) (
  input logic                clk,
  input logic                rst,
  atm_money_ctrl_p_if.slave  bus
);
  localparam int AW     = BAL_W + 1;
  localparam int ONE_W  = 2**N_SEL;
  localparam int CNT_W  = $clog2(MAX_WD + 2);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  state_t             state, state_n;
  result_t            res;
  logic               rise;
  logic [N_SEL-1:0]   sel_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [HOLD_W-1:0]  hold;
  logic [BAL_W-1:0]   balance;
  logic               ok_q, nomoney_q, limit_q;
  logic [ONE_W-1:0]   onehot_q;
  logic [AW-1:0]      amt, bal_ext, dep_sum;
  logic               hold_done;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.req),
    .rise (rise)
  );

  assign amt       = (AW'(sel_q) + AW'(1)) * AW'(STEP);
  assign bal_ext   = {1'b0, balance};
  assign dep_sum   = bal_ext + amt;
  assign hold_done = (hold == HOLD_W'(HOLD_CYC - 1));

  // Both operands fit in BAL_W bits, so the carry bit alone signals overflow.
  always_comb begin
    res = RES_OK;
    if (mode_q == MODE_WD && cnt == CNT_W'(MAX_WD))   res = RES_LIMIT;
    else if (mode_q == MODE_WD && amt > bal_ext)      res = RES_NOMONEY;
    else if (mode_q == MODE_DEP && dep_sum[BAL_W])    res = RES_LIMIT;
  end

  always_comb begin
    state_n = state;
    if (!bus.auth) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    state_n = READY;
        READY:   if (rise) state_n = CHECK;
        CHECK:   state_n = RESULT;
        RESULT:  if (hold_done) state_n = READY;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      mode_q    <= MODE_WD;
      cnt       <= '0;
      hold      <= '0;
      balance   <= BAL_W'(INIT_BAL);
      ok_q      <= 1'b0;
      nomoney_q <= 1'b0;
      limit_q   <= 1'b0;
      onehot_q  <= '0;
    end else if (!bus.auth) begin
      // Losing auth abandons any pending update and ends the session.
      cnt       <= '0;
      hold      <= '0;
      ok_q      <= 1'b0;
      nomoney_q <= 1'b0;
      limit_q   <= 1'b0;
      onehot_q  <= '0;
    end else begin
      case (state)
        IDLE: cnt <= '0;
        READY: begin
          if (rise) begin
            sel_q  <= bus.sel;
            mode_q <= bus.mode;
          end
        end
        CHECK: begin
          hold      <= '0;
          ok_q      <= (res == RES_OK);
          nomoney_q <= (res == RES_NOMONEY);
          limit_q   <= (res == RES_LIMIT);
          onehot_q  <= (res == RES_OK) ? (ONE_W'(1) << sel_q) : '0;
          if (res == RES_OK) begin
            if (mode_q == MODE_DEP) begin
              balance <= dep_sum[BAL_W-1:0];
            end else begin
              balance <= balance - amt[BAL_W-1:0];
              cnt     <= cnt + CNT_W'(1);
            end
          end
        end
        RESULT: begin
          if (hold_done) begin
            ok_q      <= 1'b0;
            nomoney_q <= 1'b0;
            limit_q   <= 1'b0;
            onehot_q  <= '0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ok            = ok_q;
  assign bus.nomoney       = nomoney_q;
  assign bus.limit         = limit_q;
  assign bus.busy          = (state == CHECK) || (state == RESULT);
  assign bus.amount_onehot = onehot_q;
  assign bus.balance       = balance;
  assign bus.state_dbg     = state;
endmodule
